// File: rtl/plot_pkg.sv
// Shared definitions for the plot sweep controller: fixed-point and screen
// defaults plus the sequencer state encoding.
package plot_pkg;

  localparam int DEF_INTEGER_PART_WIDTH    = 8;
  localparam int DEF_FRACTIONAL_PART_WIDTH = 8;
  localparam int DEF_NUMBER_WIDTH          = DEF_INTEGER_PART_WIDTH + DEF_FRACTIONAL_PART_WIDTH;

  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_X_WIDTH       = 10;
  localparam int DEF_Y_WIDTH       = 9;
  localparam int DEF_Y_CENTER      = 240;

  // x of column 0 is -20.0, each column steps by 1/16
  localparam logic [DEF_NUMBER_WIDTH-1:0] DEF_X_START = 16'hEC00;
  localparam logic [DEF_NUMBER_WIDTH-1:0] DEF_X_STEP  = 16'h0010;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    EVAL_START,
    EVAL_WAIT,
    WRITE,
    NEXT,
    DONE
  } plotState_t;

endpackage

// File: rtl/plot_sweep_controller_if.sv
// Evaluator and framebuffer signals seen by the sweep controller. The master
// side is the controller; the slave side is the evaluator/framebuffer pair.
interface plot_sweep_controller_if
  import plot_pkg::*;
#(
  parameter int NUMBER_WIDTH = DEF_NUMBER_WIDTH,
  parameter int X_WIDTH      = DEF_X_WIDTH,
  parameter int Y_WIDTH      = DEF_Y_WIDTH
) ();

  logic                    eval_start;
  logic [NUMBER_WIDTH-1:0] eval_x;
  logic                    eval_done;
  logic                    eval_error;
  logic [NUMBER_WIDTH-1:0] eval_result;

  logic                    fb_valid;
  logic                    fb_ready;
  logic [X_WIDTH-1:0]      fb_x;
  logic [Y_WIDTH-1:0]      fb_y;
  logic                    fb_color;

  modport master (
    output eval_start, eval_x,
    input  eval_done, eval_error, eval_result,
    output fb_valid, fb_x, fb_y, fb_color,
    input  fb_ready
  );

  modport slave (
    input  eval_start, eval_x,
    output eval_done, eval_error, eval_result,
    input  fb_valid, fb_x, fb_y, fb_color,
    output fb_ready
  );

endinterface

// File: rtl/plot_row_mapper.sv
// Maps the signed integer part of an evaluation result to a screen row
// (row = Y_CENTER - r) and flags whether a pixel should be drawn.
module plot_row_mapper
  import plot_pkg::*;
#(
  parameter int INT_WIDTH     = DEF_INTEGER_PART_WIDTH,
  parameter int Y_WIDTH       = DEF_Y_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int Y_CENTER      = DEF_Y_CENTER
) (
  input  logic [INT_WIDTH-1:0] resultInt_i,
  input  logic                 error_i,
  output logic [Y_WIDTH-1:0]   row_o,
  output logic                 inRange_o
);

  // Two extra bits keep the subtraction exact for any row offset, so
  // rows above or below the screen are never aliased back onto it.
  localparam int ROW_WIDTH = Y_WIDTH + 2;
  localparam logic signed [ROW_WIDTH-1:0] CENTER = ROW_WIDTH'(Y_CENTER);
  localparam logic signed [ROW_WIDTH-1:0] HEIGHT = ROW_WIDTH'(SCREEN_HEIGHT);

  logic signed [ROW_WIDTH-1:0] resultExt;
  logic signed [ROW_WIDTH-1:0] rowFull;

  // Sign-extend the integer part and compute the row with its range check
  always_comb begin
    resultExt = {{(ROW_WIDTH-INT_WIDTH){resultInt_i[INT_WIDTH-1]}}, resultInt_i};
    rowFull   = CENTER - resultExt;
    row_o     = rowFull[Y_WIDTH-1:0];
    inRange_o = !error_i && !rowFull[ROW_WIDTH-1] && (rowFull < HEIGHT);
  end

endmodule

// File: rtl/plot_sweep_controller.sv
// Sweep sequencer: clears the framebuffer, then evaluates f(x) once per
// column and writes one lit pixel at the mapped row when it is on screen.
module plot_sweep_controller
  import plot_pkg::*;
#(
  parameter int INTEGER_PART_WIDTH    = DEF_INTEGER_PART_WIDTH,
  parameter int FRACTIONAL_PART_WIDTH = DEF_FRACTIONAL_PART_WIDTH,
  parameter int NUMBER_WIDTH          = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  parameter int SCREEN_WIDTH          = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT         = DEF_SCREEN_HEIGHT,
  parameter int X_WIDTH               = DEF_X_WIDTH,
  parameter int Y_WIDTH               = DEF_Y_WIDTH,
  parameter logic [NUMBER_WIDTH-1:0] X_START = DEF_X_START,
  parameter logic [NUMBER_WIDTH-1:0] X_STEP  = DEF_X_STEP,
  parameter int Y_CENTER              = DEF_Y_CENTER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic plot_start,
  output logic plot_busy,
  output logic plot_done,
  plot_sweep_controller_if.master bus
);

  localparam logic [X_WIDTH-1:0] LAST_COL = X_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] LAST_ROW = Y_WIDTH'(SCREEN_HEIGHT - 1);

  plotState_t              state_q, state_d;
  logic [X_WIDTH-1:0]      col_q, col_d;
  logic [X_WIDTH-1:0]      fbX_q, fbX_d;
  logic [Y_WIDTH-1:0]      fbY_q, fbY_d;
  logic [NUMBER_WIDTH-1:0] evalX_q, evalX_d;

  logic [Y_WIDTH-1:0]      mappedRow;
  logic                    mappedInRange;

  plot_row_mapper #(
    .INT_WIDTH     (INTEGER_PART_WIDTH),
    .Y_WIDTH       (Y_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .Y_CENTER      (Y_CENTER)
  ) rowMapper (
    .resultInt_i (bus.eval_result[FRACTIONAL_PART_WIDTH +: INTEGER_PART_WIDTH]),
    .error_i     (bus.eval_error),
    .row_o       (mappedRow),
    .inRange_o   (mappedInRange)
  );

  // State and datapath registers; reset returns everything to an idle, blank bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      fbX_q   <= '0;
      fbY_q   <= '0;
      evalX_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      fbX_q   <= fbX_d;
      fbY_q   <= fbY_d;
      evalX_q <= evalX_d;
    end
  end

  // Next-state and datapath updates; fb_x/fb_y only move on a handshake or
  // outside the write states, so they stay stable while a write is stalled
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    fbX_d   = fbX_q;
    fbY_d   = fbY_q;
    evalX_d = evalX_q;

    case (state_q)
      IDLE: begin
        if (plot_start) begin
          state_d = CLEAR;
          fbX_d   = '0;
          fbY_d   = '0;
        end
      end

      CLEAR: begin
        if (bus.fb_ready) begin
          if (fbX_q == LAST_COL) begin
            fbX_d = '0;
            if (fbY_q == LAST_ROW) begin
              fbY_d   = '0;
              col_d   = '0;
              evalX_d = X_START;
              state_d = EVAL_START;
            end else begin
              fbY_d = fbY_q + Y_WIDTH'(1);
            end
          end else begin
            fbX_d = fbX_q + X_WIDTH'(1);
          end
        end
      end

      EVAL_START: state_d = EVAL_WAIT;

      EVAL_WAIT: begin
        if (bus.eval_done) begin
          fbX_d   = col_q;
          fbY_d   = mappedRow;
          state_d = mappedInRange ? WRITE : NEXT;
        end
      end

      WRITE: begin
        if (bus.fb_ready) state_d = NEXT;
      end

      NEXT: begin
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end else begin
          col_d   = col_q + X_WIDTH'(1);
          evalX_d = evalX_q + X_STEP;
          state_d = EVAL_START;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign plot_busy      = (state_q != IDLE);
  assign plot_done      = (state_q == DONE);
  assign bus.eval_start = (state_q == EVAL_START);
  assign bus.eval_x     = evalX_q;
  assign bus.fb_valid   = (state_q == CLEAR) || (state_q == WRITE);
  assign bus.fb_color   = (state_q == WRITE);
  assign bus.fb_x       = fbX_q;
  assign bus.fb_y       = fbY_q;

endmodule

// File: tb/tb_plot_sweep_controller.sv
// Scoreboard bench for plot_sweep_controller on a 4x4 screen centred at row 2.
module tb_plot_sweep_controller;

  localparam int NW = 16;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int YC = 2;

  localparam logic [1:0] K_FBW  = 2'd1;
  localparam logic [1:0] K_EVS  = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [NW-1:0] data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          color;
  } event_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic plot_start = 1'b0;
  logic plot_busy;
  logic plot_done;

  logic          fbReady = 1'b1;
  logic          evalDoneA = 1'b0;
  logic          evalDoneM = 1'b0;
  logic          errorA = 1'b0;
  logic [NW-1:0] resultA = '0;
  logic [NW-1:0] resultM = '0;
  logic          evalEnable = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;

  event_t expQ[$];

  // Evaluator script: two sweeps of four columns each
  logic [NW-1:0] resTable [8] = '{16'h0100, 16'hFF00, 16'h0180, 16'h0500,
                                  16'h0500, 16'h0000, 16'h0000, 16'hFE00};
  logic          errTable [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int            latTable [8] = '{1, 2, 3, 1, 2, 1, 1, 3};
  int            gapTable [8] = '{0, 3, 3, 3, 0, 2, 2, 0};

  plot_sweep_controller_if #(.NUMBER_WIDTH(NW), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

  assign bus.fb_ready    = fbReady;
  assign bus.eval_done   = evalDoneA | evalDoneM;
  assign bus.eval_error  = errorA;
  assign bus.eval_result = evalDoneM ? resultM : resultA;

  plot_sweep_controller #(
    .SCREEN_WIDTH  (SW),
    .SCREEN_HEIGHT (SH),
    .Y_CENTER      (YC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .plot_start (plot_start),
    .plot_busy  (plot_busy),
    .plot_done  (plot_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus();
    plot_start = 1'b1;
    tick();
    plot_start = 1'b0;
  endtask

  function automatic event_t mkWrite(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic c);
    event_t e;
    e = '0;
    e.kind = K_FBW;
    e.x = x;
    e.y = y;
    e.color = c;
    return e;
  endfunction

  function automatic event_t mkEval(input logic [NW-1:0] xv);
    event_t e;
    e = '0;
    e.kind = K_EVS;
    e.data = xv;
    return e;
  endfunction

  function automatic event_t mkDone();
    event_t e;
    e = '0;
    e.kind = K_DONE;
    return e;
  endfunction

  task automatic pushClear();
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        expQ.push_back(mkWrite(XW'(x), YW'(y), 1'b0));
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (plot_done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(plot_done), 64'd1);
  endtask

  task automatic waitEvalStart(input string name);
    int n;
    n = 0;
    while (bus.eval_start !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(bus.eval_start), 64'd1);
  endtask

  task automatic waitFbValid(input string name);
    int n;
    n = 0;
    while (bus.fb_valid !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(bus.fb_valid), 64'd1);
  endtask

  // Monitor: every DUT-presented event is popped against the scoreboard
  initial begin : monitor
    event_t act;
    event_t exp;
    logic have;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        have = 1'b0;
        act = '0;
        if (bus.fb_valid && bus.fb_ready) begin
          have = 1'b1;
          act = mkWrite(bus.fb_x, bus.fb_y, bus.fb_color);
        end else if (bus.eval_start) begin
          have = 1'b1;
          act = mkEval(bus.eval_x);
        end else if (plot_done) begin
          have = 1'b1;
          act = mkDone();
        end
        if (have) begin
          if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpectedEvent: actual=%0h required=none", act);
          end else begin
            exp = expQ.pop_front();
            checkOutput("scoreboard", 64'(act), 64'(exp));
          end
        end
      end
    end
  end

  // Evaluator model answering each eval_start from the script tables
  initial begin : evaluator
    int idx;
    int doneCyc;
    idx = 0;
    doneCyc = 0;
    forever begin
      tick();
      if (evalEnable && bus.eval_start && idx < 8) begin
        if (gapTable[idx] != 0)
          checkOutput("startGap", 64'(cyc - doneCyc), 64'(gapTable[idx]));
        repeat (latTable[idx]) tick();
        checkOutput("evalXHeld", 64'(bus.eval_x), 64'(16'hEC00 + 16'(16 * (idx % 4))));
        resultA = resTable[idx];
        errorA = errTable[idx];
        evalDoneA = 1'b1;
        doneCyc = cyc;
        tick();
        evalDoneA = 1'b0;
        errorA = 1'b0;
        idx++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic sawActivity;

    // Reset values
    rst_n = 1'b0;
    fbReady = 1'b1;
    repeat (3) tick();
    checkOutput("rstBusy",    64'(plot_busy),      64'd0);
    checkOutput("rstDone",    64'(plot_done),      64'd0);
    checkOutput("rstEvStart", 64'(bus.eval_start), 64'd0);
    checkOutput("rstFbValid", 64'(bus.fb_valid),   64'd0);
    checkOutput("rstColor",   64'(bus.fb_color),   64'd0);
    checkOutput("rstEvalX",   64'(bus.eval_x),     64'd0);
    checkOutput("rstFbX",     64'(bus.fb_x),       64'd0);
    checkOutput("rstFbY",     64'(bus.fb_y),       64'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of CLEAR (framebuffer stalled so no writes land)
    fbReady = 1'b0;
    applyStimulus();
    checkOutput("clearValid", 64'(bus.fb_valid), 64'd1);
    checkOutput("clearBusy",  64'(plot_busy),    64'd1);
    checkOutput("clearColor", 64'(bus.fb_color), 64'd0);
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    checkOutput("midRstBusy",  64'(plot_busy),    64'd0);
    checkOutput("midRstValid", 64'(bus.fb_valid), 64'd0);
    checkOutput("midRstDone",  64'(plot_done),    64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("postRstBusy", 64'(plot_busy), 64'd0);

    // Sweep 1: three in-range rows, last column off the top of the screen
    fbReady = 1'b1;
    evalEnable = 1'b1;
    pushClear();
    expQ.push_back(mkEval(16'hEC00));
    expQ.push_back(mkWrite(10'd0, 9'd1, 1'b1));
    expQ.push_back(mkEval(16'hEC10));
    expQ.push_back(mkWrite(10'd1, 9'd3, 1'b1));
    expQ.push_back(mkEval(16'hEC20));
    expQ.push_back(mkWrite(10'd2, 9'd1, 1'b1));
    expQ.push_back(mkEval(16'hEC30));
    expQ.push_back(mkDone());
    applyStimulus();
    waitDone("sweep1Done");
    tick();
    checkOutput("sweep1Idle",     64'(plot_busy), 64'd0);
    checkOutput("sweep1DoneOnce", 64'(plot_done), 64'd0);
    tick();
    checkOutput("sweep1Drained", 64'(expQ.size()), 64'd0);

    // Sweep 2: skips on row<0 and on error, stalled write, skip on row==height
    pushClear();
    expQ.push_back(mkEval(16'hEC00));
    expQ.push_back(mkEval(16'hEC10));
    expQ.push_back(mkEval(16'hEC20));
    expQ.push_back(mkWrite(10'd2, 9'd2, 1'b1));
    expQ.push_back(mkEval(16'hEC30));
    expQ.push_back(mkDone());
    applyStimulus();
    waitEvalStart("sweep2FirstEval");
    fbReady = 1'b0;
    waitFbValid("sweep2WriteSeen");
    checkOutput("stallX0",     64'(bus.fb_x),     64'd2);
    checkOutput("stallY0",     64'(bus.fb_y),     64'd2);
    checkOutput("stallColor0", 64'(bus.fb_color), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stallValid", 64'(bus.fb_valid), 64'd1);
      checkOutput("stallX",     64'(bus.fb_x),     64'd2);
      checkOutput("stallY",     64'(bus.fb_y),     64'd2);
      checkOutput("stallColor", 64'(bus.fb_color), 64'd1);
    end
    fbReady = 1'b1;
    waitDone("sweep2Done");
    repeat (2) tick();
    checkOutput("sweep2Drained", 64'(expQ.size()), 64'd0);

    // plot_start ignored in EVAL_WAIT; reset there, then a late eval_done
    evalEnable = 1'b0;
    pushClear();
    expQ.push_back(mkEval(16'hEC00));
    applyStimulus();
    waitEvalStart("waitTestEval");
    tick();
    checkOutput("waitBusy", 64'(plot_busy), 64'd1);
    applyStimulus();
    checkOutput("startIgnoredValid", 64'(bus.fb_valid),   64'd0);
    checkOutput("startIgnoredEval",  64'(bus.eval_start), 64'd0);
    checkOutput("startIgnoredBusy",  64'(plot_busy),      64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("waitRstBusy", 64'(plot_busy), 64'd0);
    resultM = 16'h0100;
    evalDoneM = 1'b1;
    tick();
    evalDoneM = 1'b0;
    sawActivity = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.fb_valid || plot_done || plot_busy || bus.eval_start) sawActivity = 1'b1;
    end
    checkOutput("lateDoneIgnored", 64'(sawActivity), 64'd0);
    checkOutput("finalDrained",    64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
